serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_sub_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 112 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtraction controller.
// The state encoding is fixed at two bits; the spare code 2'b11 is treated as illegal.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // busy covers both the bit-processing phase and the completion cycle
  function automatic logic is_busy(input state_t s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: D = A - B - Bin, one bit per clock, LSB first,
// sequencing a single full-subtractor cell through IDLE/RUN/DONE.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out,
  output logic             bout
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             br;
  logic [CNT_W-1:0] idx;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bo;

  full_sub_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // The result register fills from the MSB side so that after WIDTH shifts bit 0 lands at index 0
  generate
    if (WIDTH == 1) begin : g_sr_w1
      assign sr_next = cell_d;
    end else begin : g_sr_wn
      assign sr_next = {cell_d, sr[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (idx == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: next_state = start ? RUN : IDLE;
      RUN:  next_state = last_bit ? DONE : RUN;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy = is_busy(state);
    done = (state == DONE);
  end

  // Operand capture and per-bit datapath; d_out/bout only move on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      idx   <= '0;
      d_out <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a_in;
            sb  <= b_in;
            br  <= bin_in;
            sr  <= '0;
            idx <= '0;
          end
        end
        RUN: begin
          sr  <= sr_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= cell_bo;
          idx <= idx + CNT_W'(1);
          if (last_bit) begin
            d_out <= sr_next;
            bout  <= cell_bo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: an 8-bit instance and a 1-bit instance,
// checked against a plain-arithmetic model of A - B - Bin.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] a_in   = '0;
  logic [W-1:0] b_in   = '0;
  logic         bin_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d_out;
  logic         bout;

  logic start1 = 1'b0;
  logic a1     = 1'b0;
  logic b1     = 1'b0;
  logic bin1   = 1'b0;
  logic busy1;
  logic done1;
  logic d1;
  logic bout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .d_out  (d_out),
    .bout   (bout)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .a_in   (a1),
    .b_in   (b1),
    .bin_in (bin1),
    .busy   (busy1),
    .done   (done1),
    .d_out  (d1),
    .bout   (bout1)
  );

  // Reference: signed difference, wrapped modulo 2^w, borrow when it went negative
  function automatic void ref_sub(input longint a, input longint b, input longint bi,
                                  input int w, output logic [31:0] d, output logic bo);
    longint diff;
    diff = a - b - bi;
    bo   = (diff < 0);
    d    = 32'(diff & ((64'sd1 <<< w) - 1));
  endfunction

  // Issue one 8-bit transaction from IDLE and observe it for 12 cycles after the start edge
  task automatic drive_txn8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                            output int done_cyc, output int done_cnt, output int busy_bad,
                            output logic [7:0] d, output logic bo);
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    d        = '0;
    bo       = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    bin_in = bi;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
      end
      if (busy !== (cyc <= W + 1)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        d        = d_out;
        bo       = bout;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (d_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_d_out: got %h want 00", d_out); end
    checks++; if (bout !== 1'b0)  begin errors++; $display("[TB] FAIL reset_bout: got %b want 0", bout); end
    checks++; if ({busy1, done1, d1, bout1} !== 4'b0000)
      begin errors++; $display("[TB] FAIL reset_w1: got %b want 0000", {busy1, done1, d1, bout1}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: busy %b want 0", busy); end
  endtask

  task automatic test_basic();
    int dc, dn, bb;
    logic [7:0] d;
    logic bo;
    logic [31:0] ed;
    logic eb;
    ref_sub(8'h5A, 8'h3C, 0, W, ed, eb);
    drive_txn8(8'h5A, 8'h3C, 1'b0, dc, dn, bb, d, bo);
    checks++; if (dc !== W + 1) begin errors++; $display("[TB] FAIL basic_latency: done cycle %0d want %0d", dc, W + 1); end
    checks++; if (dn !== 1)     begin errors++; $display("[TB] FAIL basic_done_count: got %0d want 1", dn); end
    checks++; if (bb !== 0)     begin errors++; $display("[TB] FAIL basic_busy_window: %0d bad cycles want 0", bb); end
    checks++; if (d !== ed[7:0]) begin errors++; $display("[TB] FAIL basic_d_out: got %h want %h", d, ed[7:0]); end
    checks++; if (bo !== eb)    begin errors++; $display("[TB] FAIL basic_bout: got %b want %b", bo, eb); end
    checks++; if (d_out !== ed[7:0]) begin errors++; $display("[TB] FAIL basic_hold: got %h want %h", d_out, ed[7:0]); end
  endtask

  task automatic test_wrap();
    logic [7:0] ta [3] = '{8'h00, 8'h00, 8'hFF};
    logic [7:0] tb [3] = '{8'h01, 8'h00, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    int dc, dn, bb;
    logic [7:0] d;
    logic bo;
    logic [31:0] ed;
    logic eb;
    for (int i = 0; i < 3; i++) begin
      ref_sub(ta[i], tb[i], tc[i], W, ed, eb);
      drive_txn8(ta[i], tb[i], tc[i], dc, dn, bb, d, bo);
      checks++; if (d !== ed[7:0]) begin errors++; $display("[TB] FAIL wrap_d_out[%0d]: got %h want %h", i, d, ed[7:0]); end
      checks++; if (bo !== eb)     begin errors++; $display("[TB] FAIL wrap_bout[%0d]: got %b want %b", i, bo, eb); end
    end
  endtask

  task automatic test_ignored_start();
    int dc = 0;
    int dcyc = -1;
    logic [7:0] d = '0;
    @(negedge clk);
    start = 1'b1; a_in = 8'h10; b_in = 8'h01; bin_in = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 4) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h00; end
      if (cyc == 5) start = 1'b0;
      if (done === 1'b1) begin dc++; dcyc = cyc; d = d_out; end
    end
    checks++; if (dc !== 1)     begin errors++; $display("[TB] FAIL ignore_done_count: got %0d want 1", dc); end
    checks++; if (dcyc !== W + 1) begin errors++; $display("[TB] FAIL ignore_latency: got %0d want %0d", dcyc, W + 1); end
    checks++; if (d !== 8'h0F)  begin errors++; $display("[TB] FAIL ignore_d_out: got %h want 0f", d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_not_queued: busy %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int dc, dn, bb;
    int aborted_done = 0;
    logic [7:0] d;
    logic bo;
    logic [31:0] ed;
    logic eb;
    logic [7:0] ra, rb;
    logic rc;
    drive_txn8(8'h33, 8'h11, 1'b0, dc, dn, bb, d, bo);
    @(negedge clk);
    start = 1'b1; a_in = 8'h80; b_in = 8'h01; bin_in = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 5) begin
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        checks++; if (d_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_d_out: got %h want 00", d_out); end
        checks++; if (bout !== 1'b0)   begin errors++; $display("[TB] FAIL abort_bout: got %b want 0", bout); end
      end
      if (cyc == 7) rst_n = 1'b1;
      if (done === 1'b1) aborted_done++;
    end
    checks++; if (aborted_done !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d want 0", aborted_done); end
    checks++; if (d_out !== 8'h00)    begin errors++; $display("[TB] FAIL abort_no_partial: got %h want 00", d_out); end
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    ref_sub(ra, rb, rc, W, ed, eb);
    drive_txn8(ra, rb, rc, dc, dn, bb, d, bo);
    checks++; if (d !== ed[7:0] || bo !== eb)
      begin errors++; $display("[TB] FAIL abort_recover: got %h/%b want %h/%b", d, bo, ed[7:0], eb); end
    checks++; if (dc !== W + 1) begin errors++; $display("[TB] FAIL abort_recover_latency: got %0d want %0d", dc, W + 1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic       qc [$];
    int         acc [$];
    int         n_done = 0;
    logic       prev_busy;
    logic [7:0] ea, eb8;
    logic       ec;
    logic [31:0] ed;
    logic        ebo;
    @(negedge clk);
    prev_busy = busy;
    start = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
    for (int cyc = 1; cyc <= 80 && n_done < 5; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        qa.push_back(a_in); qb.push_back(b_in); qc.push_back(bin_in); acc.push_back(cyc);
        a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
      end
      if (done === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_spurious_done: cycle %0d with nothing outstanding", cyc);
        end else begin
          ea = qa.pop_front(); eb8 = qb.pop_front(); ec = qc.pop_front();
          ref_sub(ea, eb8, ec, W, ed, ebo);
          if (d_out !== ed[7:0] || bout !== ebo) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d]: got %h/%b want %h/%b", n_done, d_out, bout, ed[7:0], ebo);
          end
        end
        n_done++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checks++; if (n_done !== 5) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d want 5", n_done); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (i >= acc.size() || acc[i] - acc[i-1] !== W + 2) begin
        errors++;
        $display("[TB] FAIL b2b_spacing[%0d]: got %0d want %0d", i,
                 (i < acc.size()) ? acc[i] - acc[i-1] : -1, W + 2);
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: busy %b want 0", busy); end
  endtask

  task automatic test_width1();
    int dcyc;
    logic dv, bv;
    logic [31:0] ed;
    logic eb;
    for (int i = 0; i < 8; i++) begin
      dcyc = -1; dv = 1'b0; bv = 1'b0;
      ref_sub((i >> 2) & 1, (i >> 1) & 1, i & 1, 1, ed, eb);
      @(negedge clk);
      start1 = 1'b1; a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); bin1 = 1'(i & 1);
      for (int cyc = 1; cyc <= 5; cyc++) begin
        @(negedge clk);
        if (cyc == 1) start1 = 1'b0;
        if (done1 === 1'b1) begin dcyc = cyc; dv = d1; bv = bout1; end
      end
      checks++; if (dcyc !== 2) begin errors++; $display("[TB] FAIL w1_latency[%0d]: got %0d want 2", i, dcyc); end
      checks++; if (dv !== ed[0]) begin errors++; $display("[TB] FAIL w1_d[%0d]: got %b want %b", i, dv, ed[0]); end
      checks++; if (bv !== eb)    begin errors++; $display("[TB] FAIL w1_bout[%0d]: got %b want %b", i, bv, eb); end
    end
  endtask

  task automatic test_random();
    int dc, dn, bb;
    logic [7:0] d, ra, rb;
    logic bo, rc;
    logic [31:0] ed;
    logic eb;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_sub(ra, rb, rc, W, ed, eb);
      drive_txn8(ra, rb, rc, dc, dn, bb, d, bo);
      checks++;
      if (d !== ed[7:0] || bo !== eb || dc !== W + 1 || dn !== 1) begin
        errors++;
        $display("[TB] FAIL random[%0d] %h-%h-%b: got %h/%b cyc %0d n %0d want %h/%b cyc %0d n 1",
                 i, ra, rb, rc, d, bo, dc, dn, ed[7:0], eb, W + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_width1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
